my_register_universal: RTL and testbench
========================================

Name: my_register_universal

Overview:
- Parametrised successor to the team's load/increment register.
- Adds down-count, a configurable step, a modulo limit with a wrap or saturate mode, left/right shift with serial in/out, synchronous clear, and registered status flags.
- Used as a general-purpose counter, timer or shift stage in datapaths and control units.

Parameters:
- WIDTH, 8: data width in bits, minimum 2.
- STEP, 1: increment/decrement amount. Constraint: 1 <= STEP <= LIMIT.
- LIMIT, 2**WIDTH-1: upper bound of the count range. Constraint: LIMIT < 2**WIDTH.
- SATURATE, 0: overflow mode. 0 = wrap; 1 = saturate at the range bounds.

Ports:
- clk  input  1  rising-edge clock.
- asynch_nreset  input  1  asynchronous, active-low reset.
- ctrl_clr  input  1  synchronous clear of the data register.
- ctrl_load  input  1  parallel load of data_input.
- ctrl_shl  input  1  shift left; serial_in enters at the LSB.
- ctrl_shr  input  1  shift right; serial_in enters at the MSB.
- ctrl_incr  input  1  count up by STEP.
- ctrl_decr  input  1  count down by STEP.
- ctrl_clr_flags  input  1  clears the sticky overflow flag.
- serial_in  input  1  shift input bit.
- data_input  input  WIDTH  load value.
- data_output  output  WIDTH  register contents.
- serial_out  output  1  bit shifted out on the most recent shift.
- flag_zero  output  1  data_output == 0.
- flag_limit  output  1  data_output == LIMIT.
- flag_event  output  1  one-cycle pulse: a wrap or saturation occurred.
- flag_overflow_sticky  output  1  latched wrap/saturation indicator.

Behaviour:
- Reset (asynch_nreset low, asynchronous):
  - data_output=0, serial_out=0, flag_event=0, flag_overflow_sticky=0.
  - flag_zero=1, flag_limit=(LIMIT==0 ? 1 : 0).
  - Reset mid-operation discards all state immediately.
- Timing: all outputs are registered. The effect of the controls sampled at edge N is visible after edge N, i.e. one-cycle latency. flag_zero and flag_limit are derived from the next-state value and registered together with the data, so they are always coherent with data_output.
- Operation priority per cycle (highest first): ctrl_clr > ctrl_load > shift > count > hold.
- ctrl_clr: data=0. serial_out and the flags update normally (flag_event=0).
- ctrl_load: data=data_input, loaded verbatim even if greater than LIMIT.
- Shift:
  - ctrl_shl only: data={data[WIDTH-2:0], serial_in}; serial_out=old data[WIDTH-1].
  - ctrl_shr only: data={serial_in, data[WIDTH-1:1]}; serial_out=old data[0].
  - ctrl_shl and ctrl_shr together: no shift, serial_out holds, and the cycle falls through to the count stage.
  - Shifts ignore LIMIT and never raise flag_event.
- Count, ctrl_incr only:
  - Compute data+STEP in WIDTH+1 bits.
  - If the sum <= LIMIT and the old data <= LIMIT: data=sum.
  - Otherwise it is an overflow event:
    - wrap mode: data=0;
    - saturate mode: data=LIMIT.
    - If data already equals LIMIT in saturate mode, it is still an event.
- Count, ctrl_decr only:
  - If data >= STEP and data <= LIMIT: data=data-STEP.
  - If data < STEP, underflow event:
    - wrap mode: data=LIMIT;
    - saturate mode: data=0.
  - If data > LIMIT, due to a prior load: data=LIMIT, no event.
- ctrl_incr and ctrl_decr together: hold, no event.
- Events:
  - flag_event is high for exactly the cycle following an overflow or underflow; otherwise 0.
  - flag_overflow_sticky is set on any event.
  - ctrl_clr_flags clears it; set wins over clear in the same cycle.
  - ctrl_clr does not clear the sticky flag.
- serial_out changes only on an effective shift.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8, LIMIT=9, STEP=1, SATURATE=0: release reset, hold ctrl_incr for 10 cycles -> data 1..9 then 0. flag_limit high while data=9. flag_event pulses one cycle with data=0. Sticky set; cleared after one ctrl_clr_flags cycle.
- Same config, data=0, ctrl_decr one cycle -> data=9, flag_event=1, flag_limit=1. Load 200, ctrl_decr -> data=9, flag_event=0.
- WIDTH=8, LIMIT=255, STEP=3, SATURATE=1:
  - load 250, incr -> 253; incr -> 255 with event; incr -> 255 with event again.
  - load 2, decr -> 0 with event, flag_zero=1.
- Shift, default parameters, load 8'b1000_0001:
  - shl with serial_in=0 -> 8'b0000_0010, serial_out=1.
  - shr with serial_in=1 -> 8'b1000_0001, serial_out=0.
  - shl+shr together with incr -> 8'b1000_0010, serial_out unchanged.
- Priority: ctrl_clr+ctrl_load+ctrl_incr with data_input=0x55 -> data=0. ctrl_load+ctrl_shl -> data=data_input.
- Drive asynch_nreset low mid-count between clock edges -> all outputs reach their reset values immediately, without waiting for a clock edge. Counting resumes from 0 on the first edge after release.

Source files
------------

// File: rtl/my_register_universal_if.sv
// my_register_universal_if: control, data and status bundle
// for the universal counter/shift register.
interface my_register_universal_if #(
    parameter int WIDTH = 8
);
    logic             ctrl_clr;
    logic             ctrl_load;
    logic             ctrl_shl;
    logic             ctrl_shr;
    logic             ctrl_incr;
    logic             ctrl_decr;
    logic             ctrl_clr_flags;
    logic             serial_in;
    logic [WIDTH-1:0] data_input;
    logic [WIDTH-1:0] data_output;
    logic             serial_out;
    logic             flag_zero;
    logic             flag_limit;
    logic             flag_event;
    logic             flag_overflow_sticky;

    modport master (
        output ctrl_clr, ctrl_load, ctrl_shl, ctrl_shr,
        output ctrl_incr, ctrl_decr, ctrl_clr_flags,
        output serial_in, data_input,
        input  data_output, serial_out, flag_zero,
        input  flag_limit, flag_event, flag_overflow_sticky
    );

    modport slave (
        input  ctrl_clr, ctrl_load, ctrl_shl, ctrl_shr,
        input  ctrl_incr, ctrl_decr, ctrl_clr_flags,
        input  serial_in, data_input,
        output data_output, serial_out, flag_zero,
        output flag_limit, flag_event, flag_overflow_sticky
    );
endinterface

// File: rtl/my_register_universal.sv
// my_register_universal: load / shift / up-down modulo counter
// with wrap or saturate mode and registered status flags.
module my_register_universal #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int LIMIT    = (1 << WIDTH) - 1,
    parameter int SATURATE = 0
) (
    input logic                  clk,
    input logic                  asynch_nreset,
    my_register_universal_if.slave bus
);
    localparam logic [WIDTH-1:0] LIM_W  = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic             LIM_Z  = (LIMIT == 0);
    localparam logic             SAT    = (SATURATE != 0);

    logic [WIDTH-1:0] data;
    logic             sout;
    logic             sticky;

    logic [WIDTH-1:0] data_nxt;
    logic             sout_nxt;
    logic             event_nxt;
    logic             sticky_nxt;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, data} + {1'b0, STEP_W};

    // Next-state selection: clear > load > shift > count > hold.
    always_comb begin
        data_nxt  = data;
        sout_nxt  = sout;
        event_nxt = 1'b0;
        if (bus.ctrl_clr) begin
            data_nxt = '0;
        end else if (bus.ctrl_load) begin
            data_nxt = bus.data_input;
        end else if (bus.ctrl_shl ^ bus.ctrl_shr) begin
            if (bus.ctrl_shl) begin
                data_nxt = {data[WIDTH-2:0], bus.serial_in};
                sout_nxt = data[WIDTH-1];
            end else begin
                data_nxt = {bus.serial_in, data[WIDTH-1:1]};
                sout_nxt = data[0];
            end
        end else if (bus.ctrl_incr ^ bus.ctrl_decr) begin
            if (bus.ctrl_incr) begin
                if (sum <= {1'b0, LIM_W} && data <= LIM_W) begin
                    data_nxt = sum[WIDTH-1:0];
                end else begin
                    event_nxt = 1'b1;
                    data_nxt  = SAT ? LIM_W : '0;
                end
            end else begin
                // A value loaded above the range snaps back to LIMIT.
                if (data > LIM_W) begin
                    data_nxt = LIM_W;
                end else if (data >= STEP_W) begin
                    data_nxt = data - STEP_W;
                end else begin
                    event_nxt = 1'b1;
                    data_nxt  = SAT ? '0 : LIM_W;
                end
            end
        end
        sticky_nxt = event_nxt | (sticky & ~bus.ctrl_clr_flags);
    end

    // State and flags register; flags derive from next-state data.
    always_ff @(posedge clk or negedge asynch_nreset) begin
        if (!asynch_nreset) begin
            data           <= '0;
            sout           <= 1'b0;
            sticky         <= 1'b0;
            bus.flag_zero  <= 1'b1;
            bus.flag_limit <= LIM_Z;
            bus.flag_event <= 1'b0;
        end else begin
            data           <= data_nxt;
            sout           <= sout_nxt;
            sticky         <= sticky_nxt;
            bus.flag_zero  <= (data_nxt == '0);
            bus.flag_limit <= (data_nxt == LIM_W);
            bus.flag_event <= event_nxt;
        end
    end

    assign bus.data_output          = data;
    assign bus.serial_out           = sout;
    assign bus.flag_overflow_sticky = sticky;
endmodule

// File: tb/tb_my_register_universal.sv
// tb_my_register_universal: directed scoreboard bench over
// three parameter sets of my_register_universal.
module tb_my_register_universal;
    logic clk = 1'b0;
    logic asynch_nreset;

    always #5 clk = ~clk;

    my_register_universal_if #(.WIDTH(8)) ia ();
    my_register_universal_if #(.WIDTH(8)) ib ();
    my_register_universal_if #(.WIDTH(8)) ic ();

    my_register_universal #(
        .WIDTH(8), .STEP(1), .LIMIT(9), .SATURATE(0)
    ) dut_a (.clk(clk), .asynch_nreset(asynch_nreset), .bus(ia));

    my_register_universal #(
        .WIDTH(8), .STEP(3), .LIMIT(255), .SATURATE(1)
    ) dut_b (.clk(clk), .asynch_nreset(asynch_nreset), .bus(ib));

    my_register_universal #(
        .WIDTH(8)
    ) dut_c (.clk(clk), .asynch_nreset(asynch_nreset), .bus(ic));

    typedef struct packed {
        logic [7:0] d;
        logic       so;
        logic       z;
        logic       l;
        logic       e;
        logic       s;
    } obs_t;

    typedef struct {
        string tag;
        int    sel;
        obs_t  exp;
    } sb_t;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] CLR  = 7'b1000000;
    localparam logic [6:0] LOAD = 7'b0100000;
    localparam logic [6:0] SHL  = 7'b0010000;
    localparam logic [6:0] SHR  = 7'b0001000;
    localparam logic [6:0] INC  = 7'b0000100;
    localparam logic [6:0] DEC  = 7'b0000010;
    localparam logic [6:0] CLRF = 7'b0000001;

    sb_t sb[$];
    int  applied = 0;
    int  fails   = 0;

    task automatic drive(input int sel, input logic [6:0] c,
                         input logic sin, input logic [7:0] din);
        case (sel)
            0: begin
                {ia.ctrl_clr, ia.ctrl_load, ia.ctrl_shl, ia.ctrl_shr,
                 ia.ctrl_incr, ia.ctrl_decr, ia.ctrl_clr_flags} = c;
                ia.serial_in  = sin;
                ia.data_input = din;
            end
            1: begin
                {ib.ctrl_clr, ib.ctrl_load, ib.ctrl_shl, ib.ctrl_shr,
                 ib.ctrl_incr, ib.ctrl_decr, ib.ctrl_clr_flags} = c;
                ib.serial_in  = sin;
                ib.data_input = din;
            end
            default: begin
                {ic.ctrl_clr, ic.ctrl_load, ic.ctrl_shl, ic.ctrl_shr,
                 ic.ctrl_incr, ic.ctrl_decr, ic.ctrl_clr_flags} = c;
                ic.serial_in  = sin;
                ic.data_input = din;
            end
        endcase
    endtask

    function automatic obs_t observe(input int sel);
        case (sel)
            0: return {ia.data_output, ia.serial_out, ia.flag_zero,
                       ia.flag_limit, ia.flag_event,
                       ia.flag_overflow_sticky};
            1: return {ib.data_output, ib.serial_out, ib.flag_zero,
                       ib.flag_limit, ib.flag_event,
                       ib.flag_overflow_sticky};
            default: return {ic.data_output, ic.serial_out,
                             ic.flag_zero, ic.flag_limit,
                             ic.flag_event, ic.flag_overflow_sticky};
        endcase
    endfunction

    // Expected snapshot; zero/limit flags follow from the data value.
    function automatic obs_t mk(input int sel, input logic [7:0] d,
                                input logic so, input logic e,
                                input logic s);
        logic [7:0] lim;
        obs_t       o;
        lim  = (sel == 0) ? 8'd9 : 8'd255;
        o.d  = d;
        o.so = so;
        o.z  = (d == 8'd0);
        o.l  = (d == lim);
        o.e  = e;
        o.s  = s;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got,
                         input obs_t exp);
        applied++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int sel, input logic [6:0] c,
                        input logic sin, input logic [7:0] din,
                        input obs_t exp, input string tag);
        sb_t ent;
        drive(sel, c, sin, din);
        sb.push_back('{tag, sel, exp});
        @(posedge clk);
        #1;
        ent = sb.pop_front();
        check(ent.tag, observe(ent.sel), ent.exp);
        drive(sel, NONE, 1'b0, 8'h00);
    endtask

    initial begin
        asynch_nreset = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, NONE, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check("reset", observe(k), mk(k, 8'd0, 0, 0, 0));
        asynch_nreset = 1'b1;

        // Modulo-10 wrap counter
        for (int i = 0; i < 10; i++)
            step(0, INC, 0, 0,
                 mk(0, (i < 9) ? 8'(i + 1) : 8'd0, 0, i == 9, i == 9),
                 "a_incr");
        step(0, CLRF, 0, 0, mk(0, 8'd0, 0, 0, 0), "a_clrflags");
        step(0, DEC, 0, 0, mk(0, 8'd9, 0, 1, 1), "a_decr_wrap");
        step(0, LOAD, 0, 8'd200, mk(0, 8'd200, 0, 0, 1), "a_load_over");
        step(0, DEC, 0, 0, mk(0, 8'd9, 0, 0, 1), "a_decr_over");
        step(0, INC, 0, 0, mk(0, 8'd0, 0, 1, 1), "a_incr_wrap");
        step(0, INC, 0, 0, mk(0, 8'd1, 0, 0, 1), "a_incr_one");
        step(0, CLR | LOAD | INC, 0, 8'h55,
             mk(0, 8'd0, 0, 0, 1), "a_prio_clr");
        step(0, LOAD | SHL, 0, 8'h55,
             mk(0, 8'h55, 0, 0, 1), "a_prio_load");
        step(0, INC | DEC, 0, 0, mk(0, 8'h55, 0, 0, 1), "a_incdec_hold");
        step(0, INC, 0, 0, mk(0, 8'd0, 0, 1, 1), "a_incr_above");
        step(0, CLRF | INC, 0, 0, mk(0, 8'd1, 0, 0, 0), "a_clrf_incr");
        step(0, INC, 0, 0, mk(0, 8'd2, 0, 0, 0), "a_incr2");
        step(0, INC, 0, 0, mk(0, 8'd3, 0, 0, 0), "a_incr3");

        // Step-3 saturating counter
        step(1, LOAD, 0, 8'd250, mk(1, 8'd250, 0, 0, 0), "b_load");
        step(1, INC, 0, 0, mk(1, 8'd253, 0, 0, 0), "b_incr");
        step(1, INC, 0, 0, mk(1, 8'd255, 0, 1, 1), "b_sat");
        step(1, INC, 0, 0, mk(1, 8'd255, 0, 1, 1), "b_sat_again");
        step(1, LOAD, 0, 8'd2, mk(1, 8'd2, 0, 0, 1), "b_load2");
        step(1, DEC, 0, 0, mk(1, 8'd0, 0, 1, 1), "b_sat_low");

        // Shifting on default parameters
        step(2, LOAD, 0, 8'h81, mk(2, 8'h81, 0, 0, 0), "c_load");
        step(2, SHL, 0, 0, mk(2, 8'h02, 1, 0, 0), "c_shl");
        step(2, SHR, 1, 0, mk(2, 8'h81, 0, 0, 0), "c_shr");
        step(2, SHL | SHR | INC, 1, 0,
             mk(2, 8'h82, 0, 0, 0), "c_shlshr_incr");
        step(2, SHR, 0, 0, mk(2, 8'h41, 0, 0, 0), "c_shr0");
        step(2, SHL, 1, 0, mk(2, 8'h83, 0, 0, 0), "c_shl1");
        step(2, SHR, 0, 0, mk(2, 8'h41, 1, 0, 0), "c_shr_out1");
        step(2, LOAD, 0, 8'hFF, mk(2, 8'hFF, 1, 0, 0), "c_load_ff");
        step(2, INC, 0, 0, mk(2, 8'h00, 1, 1, 1), "c_wrap");

        // Asynchronous reset between clock edges while counting
        drive(0, INC, 1'b0, 8'h00);
        #2;
        asynch_nreset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            check("rst_async", observe(k), mk(k, 8'd0, 0, 0, 0));
        asynch_nreset = 1'b1;
        step(0, INC, 0, 0, mk(0, 8'd1, 0, 0, 0), "a_resume");

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, fails);
        $finish;
    end
endmodule
